// File: rtl/mem_responder_if.sv
// Initiator/responder handshake bundle for the wait-state memory responder.
interface mem_responder_if #(
    parameter int BITS_DATA = 32,
    parameter int BITS_ADDR = 16
);
    logic                 req;
    logic                 write;
    logic [BITS_ADDR-1:0] addr;
    logic [BITS_DATA-1:0] wdata;
    logic [BITS_DATA-1:0] rdata;
    logic                 ack;
    logic                 busy;
    logic                 err;

    modport master (
        output req, write, addr, wdata,
        input  rdata, ack, busy, err
    );

    modport slave (
        input  req, write, addr, wdata,
        output rdata, ack, busy, err
    );
endinterface

// File: rtl/mem_responder.sv
// Single-port word memory answering one request at a time after a fixed
// number of wait states; out-of-range addresses respond with err and zero data.
module mem_responder #(
    parameter int BITS_DATA   = 32,
    parameter int BITS_ADDR   = 16,
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_STATES = 2
) (
    input  logic            clk,
    input  logic            reset,
    mem_responder_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t               state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic                 write_q, write_d;
    logic [BITS_ADDR-1:0] addr_q, addr_d;
    logic [BITS_DATA-1:0] wdata_q, wdata_d;
    logic [BITS_DATA-1:0] rdata_q, rdata_d;
    logic                 ack_q, ack_d;
    logic                 busy_q, busy_d;
    logic                 err_q, err_d;

    logic [BITS_DATA-1:0]  mem [2**DEPTH_LOG2];
    logic                  mem_we;
    logic [DEPTH_LOG2-1:0] idx;
    logic                  in_range;

    assign idx      = addr_q[DEPTH_LOG2-1:0];
    // Shift rather than slice so DEPTH_LOG2 == BITS_ADDR stays legal.
    assign in_range = ((addr_q >> DEPTH_LOG2) == '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        mem_we  = 1'b0;

        if (reset) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            rdata_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.req) begin
                        write_d = bus.write;
                        addr_d  = bus.addr;
                        wdata_d = bus.wdata;
                        cnt_d   = 4'(WAIT_STATES);
                        state_d = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - 4'd1;
                    end else begin
                        state_d = ST_RESP;
                        ack_d   = 1'b1;
                        if (!in_range) begin
                            rdata_d = '0;
                            err_d   = 1'b1;
                        end else if (write_q) begin
                            mem_we = 1'b1;
                        end else begin
                            rdata_d = mem[idx];
                        end
                    end
                end
                ST_RESP: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        write_q <= write_d;
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
        rdata_q <= rdata_d;
        ack_q   <= ack_d;
        busy_q  <= busy_d;
        err_q   <= err_d;
        if (mem_we) begin
            mem[idx] <= wdata_q;
        end
    end

    assign bus.rdata = rdata_q;
    assign bus.ack   = ack_q;
    assign bus.busy  = busy_q;
    assign bus.err   = err_q;
endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: driver pushes expected responses from a
// word-level memory model; a negedge monitor pops and compares on every ack.
module tb_mem_responder;
    localparam int WS      = 2;
    localparam int DEPTH   = 1024;
    localparam int LAT_NEG = WS + 2;

    typedef struct {
        int          cyc;
        logic [31:0] rd;
        logic        err;
    } sb_item_t;

    typedef struct {
        string       name;
        logic        ack;
        logic        busy;
        logic        err;
        logic [31:0] rdata;
    } chk_item_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    sb_item_t    sb_q[$];
    chk_item_t   chk_q[$];
    logic [31:0] ref_mem [int];
    int          wr_addrs[$];
    logic [31:0] last_rd = '0;

    mem_responder_if #(.BITS_DATA(32), .BITS_ADDR(16)) bus ();

    mem_responder #(
        .BITS_DATA  (32),
        .BITS_ADDR  (16),
        .DEPTH_LOG2 (10),
        .WAIT_STATES(WS)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: response scoreboard plus queued idle-state checks.
    always @(negedge clk) begin
        if (chk_q.size() > 0) begin
            chk_item_t c;
            c = chk_q.pop_front();
            total += 4;
            if (bus.ack !== c.ack) begin bad++; $display("FAIL %s ack: got %b want %b", c.name, bus.ack, c.ack); end
            if (bus.busy !== c.busy) begin bad++; $display("FAIL %s busy: got %b want %b", c.name, bus.busy, c.busy); end
            if (bus.err !== c.err) begin bad++; $display("FAIL %s err: got %b want %b", c.name, bus.err, c.err); end
            if (bus.rdata !== c.rdata) begin bad++; $display("FAIL %s rdata: got %h want %h", c.name, bus.rdata, c.rdata); end
        end
        if (bus.ack === 1'b1) begin
            if (sb_q.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_ack: got ack=1 at cycle %0d want no ack", cyc);
            end else begin
                sb_item_t e;
                e = sb_q.pop_front();
                total += 3;
                if (cyc != e.cyc) begin bad++; $display("FAIL ack_cycle: got %0d want %0d", cyc, e.cyc); end
                if (bus.rdata !== e.rd) begin bad++; $display("FAIL resp_rdata: got %h want %h", bus.rdata, e.rd); end
                if (bus.err !== e.err) begin bad++; $display("FAIL resp_err: got %b want %b", bus.err, e.err); end
            end
        end else if (sb_q.size() > 0 && cyc >= sb_q[0].cyc) begin
            total++; bad++;
            $display("FAIL missing_ack: got no ack at cycle %0d want ack at %0d", cyc, sb_q[0].cyc);
            void'(sb_q.pop_front());
        end
    end

    // Called at a negedge just before the accepting posedge.
    task automatic model_push(input bit w, input int a, input logic [31:0] d);
        sb_item_t it;
        it.cyc = cyc + LAT_NEG;
        if (a >= DEPTH) begin
            it.rd  = '0;
            it.err = 1'b1;
        end else if (w) begin
            ref_mem[a] = d;
            wr_addrs.push_back(a);
            it.rd  = last_rd;
            it.err = 1'b0;
        end else begin
            it.rd  = ref_mem[a];
            it.err = 1'b0;
        end
        last_rd = it.rd;
        sb_q.push_back(it);
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (bus.busy !== 1'b0 && n < 50) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic issue(input bit w, input int a, input logic [31:0] d, input bit track);
        wait_idle();
        bus.req   = 1'b1;
        bus.write = w;
        bus.addr  = 16'(a);
        bus.wdata = d;
        if (track) model_push(w, a, d);
        @(negedge clk);
        // Scramble inputs while busy; the latched transfer must not see them.
        bus.req   = 1'b0;
        bus.write = 1'($urandom_range(0, 1));
        bus.addr  = 16'($urandom);
        bus.wdata = $urandom;
    endtask

    task automatic push_idle_chk(input string name);
        chk_item_t c;
        c.name = name; c.ack = 1'b0; c.busy = 1'b0; c.err = 1'b0; c.rdata = '0;
        chk_q.push_back(c);
    endtask

    initial begin
        int a;
        bit w;
        int n;

        reset     = 1'b1;
        bus.req   = 1'b0;
        bus.write = 1'b0;
        bus.addr  = '0;
        bus.wdata = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        push_idle_chk("after_reset");

        issue(1'b1, 0, 32'h1111_0000, 1'b1);
        issue(1'b1, 7, 32'h7777_0007, 1'b1);

        issue(1'b1, 5, 32'hCAFE_0001, 1'b1);
        issue(1'b0, 5, 32'h0, 1'b1);

        issue(1'b1, 16'h0400, 32'hDEAD_BEEF, 1'b1);
        issue(1'b0, 0, 32'h0, 1'b1);

        // Reset lands on the edge after acceptance, aborting the store.
        issue(1'b1, 7, 32'hBAD0_0007, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        reset   = 1'b0;
        last_rd = '0;
        push_idle_chk("after_abort");
        repeat (2) @(negedge clk);
        issue(1'b0, 7, 32'h0, 1'b1);

        // Continuous req: accepts land every WS+3 cycles regardless of addr churn.
        wait_idle();
        bus.req   = 1'b1;
        bus.write = 1'b0;
        for (int i = 0; i < 20; i++) begin
            a = wr_addrs[$urandom_range(0, wr_addrs.size() - 1)];
            bus.addr = 16'(a);
            if (i % (WS + 3) == 0) model_push(1'b0, a, 32'h0);
            @(negedge clk);
        end
        bus.req = 1'b0;

        for (int i = 0; i < 40; i++) begin
            w = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) begin
                a = int'($urandom_range(DEPTH, 65535));
            end else if (w) begin
                a = int'($urandom_range(0, DEPTH - 1));
            end else begin
                a = wr_addrs[$urandom_range(0, wr_addrs.size() - 1)];
            end
            issue(w, a, $urandom, 1'b1);
            if (w && a < DEPTH && $urandom_range(0, 1) == 1) issue(1'b0, a, 32'h0, 1'b1);
        end

        n = 0;
        while ((sb_q.size() > 0 || chk_q.size() > 0) && n < 40) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
